// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 16-bit 5-stage pipeline.
// Owns the PC, talks to a variable-latency instruction memory over an
// enable/ready handshake, and feeds a registered instr / PC+1 / valid
// triple to the IF/ID register. Handles stall, redirect and HLT shutdown.
//
// Handshake: a request is outstanding on every cycle im_rd_en=1; it
// completes in the cycle where im_rd_en=1 and im_rdy=1 (possibly the same
// cycle it was raised). im_addr is stable for as long as the request waits,
// unless a redirect retargets the PC. When im_rd_en drops, the memory must
// forget any pending response.
module if_fetch_stage #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] NOP_INSTR  = 16'h0000,
   parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        im_rd_en,
   output logic [15:0] im_addr,
   input  logic        im_rdy,
   input  logic [15:0] im_instr,
   output logic [15:0] fetch_instr,
   output logic [15:0] fetch_pc_plus1,
   output logic        fetch_valid,
   output logic        fetch_halted
);

   // ISSUE: may raise a new request; WAIT: request outstanding;
   // HOLD: word captured during a stall, waiting to be presented;
   // HALTED: HLT seen, no fetching until redirect.
   typedef enum logic [1:0] {
      ST_ISSUE  = 2'd0,
      ST_WAIT   = 2'd1,
      ST_HOLD   = 2'd2,
      ST_HALTED = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic        drop_q, drop_d;
   logic [15:0] hold_instr_q, hold_instr_d;
   logic [15:0] hold_pc1_q, hold_pc1_d;
   logic [15:0] fetch_instr_q, fetch_instr_d;
   logic [15:0] fetch_pc1_q, fetch_pc1_d;
   logic        fetch_valid_q, fetch_valid_d;
   logic        fetch_halted_q, fetch_halted_d;
   logic [15:0] pc_plus1;

   assign pc_plus1       = pc_q + 16'd1;
   assign fetch_instr    = fetch_instr_q;
   assign fetch_pc_plus1 = fetch_pc1_q;
   assign fetch_valid    = fetch_valid_q;
   assign fetch_halted   = fetch_halted_q;

   // Memory request decode: new request in ISSUE when not held off, kept up in WAIT.
   always_comb begin
      im_rd_en = ((state_q == ST_ISSUE) && !stall && !redirect) ||
                 (state_q == ST_WAIT);
      im_addr  = pc_q;
   end

   // Next-state, PC, hold buffer and fetch outputs; redirect overrides everything.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      drop_d         = drop_q;
      hold_instr_d   = hold_instr_q;
      hold_pc1_d     = hold_pc1_q;
      fetch_instr_d  = fetch_instr_q;
      fetch_pc1_d    = fetch_pc1_q;
      fetch_valid_d  = fetch_valid_q;
      fetch_halted_d = fetch_halted_q;

      if (redirect) begin
         pc_d           = redirect_pc;
         fetch_valid_d  = 1'b0;
         fetch_instr_d  = NOP_INSTR;
         fetch_halted_d = 1'b0;
         hold_instr_d   = NOP_INSTR;
         hold_pc1_d     = 16'h0000;
         if ((state_q == ST_WAIT) && !im_rdy) begin
            // The old response is still on its way; swallow it when it lands.
            state_d = ST_WAIT;
            drop_d  = 1'b1;
         end else begin
            state_d = ST_ISSUE;
            drop_d  = 1'b0;
         end
      end else begin
         case (state_q)
            ST_ISSUE: begin
               if (im_rd_en) begin
                  if (im_rdy) begin
                     fetch_instr_d = im_instr;
                     fetch_pc1_d   = pc_plus1;
                     fetch_valid_d = 1'b1;
                     pc_d          = pc_plus1;
                     if (im_instr[15:12] == HLT_OPCODE) begin
                        state_d        = ST_HALTED;
                        fetch_halted_d = 1'b1;
                     end
                  end else begin
                     state_d       = ST_WAIT;
                     fetch_valid_d = 1'b0;
                     fetch_instr_d = NOP_INSTR;
                  end
               end
            end
            ST_WAIT: begin
               if (im_rdy && drop_q) begin
                  drop_d  = 1'b0;
                  state_d = ST_ISSUE;
                  if (!stall) begin
                     fetch_valid_d = 1'b0;
                     fetch_instr_d = NOP_INSTR;
                  end
               end else if (im_rdy && !stall) begin
                  fetch_instr_d = im_instr;
                  fetch_pc1_d   = pc_plus1;
                  fetch_valid_d = 1'b1;
                  pc_d          = pc_plus1;
                  if (im_instr[15:12] == HLT_OPCODE) begin
                     state_d        = ST_HALTED;
                     fetch_halted_d = 1'b1;
                  end else begin
                     state_d = ST_ISSUE;
                  end
               end else if (im_rdy) begin
                  // Response arrived under stall: park it so nothing is lost.
                  hold_instr_d = im_instr;
                  hold_pc1_d   = pc_plus1;
                  pc_d         = pc_plus1;
                  state_d      = ST_HOLD;
               end else if (!stall) begin
                  fetch_valid_d = 1'b0;
                  fetch_instr_d = NOP_INSTR;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  fetch_instr_d = hold_instr_q;
                  fetch_pc1_d   = hold_pc1_q;
                  fetch_valid_d = 1'b1;
                  if (hold_instr_q[15:12] == HLT_OPCODE) begin
                     state_d        = ST_HALTED;
                     fetch_halted_d = 1'b1;
                  end else begin
                     state_d = ST_ISSUE;
                  end
               end
            end
            ST_HALTED: begin
               if (!stall) begin
                  fetch_valid_d = 1'b0;
                  fetch_instr_d = NOP_INSTR;
               end
            end
            default: state_d = ST_ISSUE;
         endcase
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_ISSUE;
         pc_q           <= RESET_PC;
         drop_q         <= 1'b0;
         hold_instr_q   <= NOP_INSTR;
         hold_pc1_q     <= 16'h0000;
         fetch_instr_q  <= NOP_INSTR;
         fetch_pc1_q    <= 16'h0000;
         fetch_valid_q  <= 1'b0;
         fetch_halted_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         drop_q         <= drop_d;
         hold_instr_q   <= hold_instr_d;
         hold_pc1_q     <= hold_pc1_d;
         fetch_instr_q  <= fetch_instr_d;
         fetch_pc1_q    <= fetch_pc1_d;
         fetch_valid_q  <= fetch_valid_d;
         fetch_halted_q <= fetch_halted_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized stall,
// redirect and memory-ready traffic, checked every cycle against a
// transaction-level model of the fetch stream.
module tb_if_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        im_rd_en;
   logic [15:0] im_addr;
   logic        im_rdy;
   logic [15:0] im_instr;
   logic [15:0] fetch_instr;
   logic [15:0] fetch_pc_plus1;
   logic        fetch_valid;
   logic        fetch_halted;

   int n_checks = 0;
   int n_pass   = 0;

   if_fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .im_rd_en      (im_rd_en),
      .im_addr       (im_addr),
      .im_rdy        (im_rdy),
      .im_instr      (im_instr),
      .fetch_instr   (fetch_instr),
      .fetch_pc_plus1(fetch_pc_plus1),
      .fetch_valid   (fetch_valid),
      .fetch_halted  (fetch_halted)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- memory model ----------------
   logic [15:0] mem [0:255];
   logic        use_lat;
   int          lat;
   logic        rdy_rand;
   int          wait_cnt;
   logic        mem_ready;

   assign mem_ready = use_lat ? (wait_cnt >= lat) : rdy_rand;
   assign im_rdy    = im_rd_en && mem_ready;
   assign im_instr  = im_rdy ? mem[im_addr[7:0]] : 16'hDEAD;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 wait_cnt <= 0;
      else if (im_rd_en && !im_rdy) wait_cnt <= wait_cnt + 1;
      else                        wait_cnt <= 0;
   end

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic [15:0] m_pc;
   logic        m_waiting, m_drop, m_halted, m_hold_valid;
   logic [15:0] m_hold_instr, m_hold_pc1;
   logic [15:0] exp_instr, exp_pc1;
   logic        exp_valid, exp_halted;
   logic        m_req, m_hs;

   task automatic model_reset();
      m_pc = 16'h0000; m_waiting = 0; m_drop = 0; m_halted = 0; m_hold_valid = 0;
      m_hold_instr = 0; m_hold_pc1 = 0;
      exp_instr = 16'h0000; exp_pc1 = 16'h0000; exp_valid = 0; exp_halted = 0;
   endtask

   task automatic m_bubble();
      exp_valid = 0; exp_instr = 16'h0000;
   endtask

   task automatic m_present(input logic [15:0] w, input logic [15:0] p1);
      exp_instr = w; exp_pc1 = p1; exp_valid = 1;
      if (w[15:12] == 4'hF) begin m_halted = 1; exp_halted = 1; end
   endtask

   // Advance the model across the coming rising edge using the inputs now on the pins.
   task automatic model_step();
      logic [15:0] word, nxt;
      word = mem[m_pc[7:0]];
      nxt  = m_pc + 16'd1;
      m_hs = m_req && mem_ready;
      if (redirect) begin
         m_pc = redirect_pc; m_bubble(); exp_halted = 0; m_halted = 0; m_hold_valid = 0;
         if (m_waiting && !m_hs) m_drop = 1;
         else begin m_waiting = 0; m_drop = 0; end
      end else if (m_hs && m_drop) begin
         m_drop = 0; m_waiting = 0;
         if (!stall) m_bubble();
      end else if (m_hs) begin
         m_waiting = 0;
         if (stall) begin m_hold_valid = 1; m_hold_instr = word; m_hold_pc1 = nxt; end
         else m_present(word, nxt);
         m_pc = nxt;
      end else if (m_req) begin
         m_waiting = 1;
         if (!stall) m_bubble();
      end else if (m_hold_valid && !stall) begin
         m_present(m_hold_instr, m_hold_pc1);
         m_hold_valid = 0;
      end else if (m_halted && !stall) begin
         m_bubble();
      end
   endtask

   // Compare process: every falling edge, registered outputs and the request.
   always @(negedge clk) begin
      if (!rst_n) begin
         model_reset();
         chk("rst_instr", fetch_instr, 16'h0000);
         chk("rst_pc1", fetch_pc_plus1, 16'h0000);
         chk("rst_valid", {15'b0, fetch_valid}, 16'd0);
         chk("rst_halted", {15'b0, fetch_halted}, 16'd0);
      end else begin
         chk("valid", {15'b0, fetch_valid}, {15'b0, exp_valid});
         chk("instr", fetch_instr, exp_instr);
         chk("pc1", fetch_pc_plus1, exp_pc1);
         chk("halted", {15'b0, fetch_halted}, {15'b0, exp_halted});
         m_req = !m_halted && !m_hold_valid && (m_waiting || (!stall && !redirect));
         chk("rd_en", {15'b0, im_rd_en}, {15'b0, m_req});
         if (m_req) chk("addr", im_addr, m_pc);
         model_step();
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_redirect(input logic [15:0] pc);
      redirect = 1; redirect_pc = pc;
      tick();
      redirect = 0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!fetch_valid && n < 20) begin tick(); n++; end
      chk(name, {15'b0, fetch_valid}, 16'd1);
   endtask

   initial begin
      int bad;
      rst_n = 1; stall = 0; redirect = 0; redirect_pc = 0;
      use_lat = 1; lat = 0; rdy_rand = 0;
      for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
      mem[0] = 16'h1123; mem[1] = 16'h2234; mem[2] = 16'h3345;
      mem[5] = 16'h4405; mem[7] = 16'hF000;
      mem[8'h10] = 16'h5A10; mem[8'h11] = 16'h6B11;
      mem[8'h40] = 16'h7C40; mem[8'hFF] = 16'h1FFF;

      #1 rst_n = 0;
      #2;
      chk("reset_valid", {15'b0, fetch_valid}, 16'd0);
      chk("reset_instr", fetch_instr, 16'h0000);
      tick(); tick();
      rst_n = 1;
      #1 chk("release_valid", {15'b0, fetch_valid}, 16'd0);

      // zero-wait stream
      tick(); #1;
      chk("zw0_instr", fetch_instr, 16'h1123); chk("zw0_pc1", fetch_pc_plus1, 16'h0001);
      chk("zw0_valid", {15'b0, fetch_valid}, 16'd1);
      tick(); #1;
      chk("zw1_instr", fetch_instr, 16'h2234); chk("zw1_pc1", fetch_pc_plus1, 16'h0002);
      tick(); #1;
      chk("zw2_instr", fetch_instr, 16'h3345); chk("zw2_pc1", fetch_pc_plus1, 16'h0003);

      // two-cycle latency from 0x0010
      lat = 1;
      do_redirect(16'h0010);
      #1;
      chk("lat_flush_valid", {15'b0, fetch_valid}, 16'd0);
      chk("lat_addr_a", im_addr, 16'h0010);
      tick(); #1;
      chk("lat_bubble_instr", fetch_instr, 16'h0000);
      chk("lat_addr_b", im_addr, 16'h0010);
      chk("lat_rd_en_b", {15'b0, im_rd_en}, 16'd1);
      tick(); #1;
      chk("lat_word", fetch_instr, 16'h5A10); chk("lat_pc1", fetch_pc_plus1, 16'h0011);

      // stall for 3 cycles while the 0x0011 response arrives
      tick();
      stall = 1;
      tick(); #1 chk("stall_frozen_a", {15'b0, fetch_valid}, 16'd0);
      tick(); #1 chk("stall_no_req", {15'b0, im_rd_en}, 16'd0);
      tick();
      stall = 0;
      tick(); #1;
      chk("hold_word", fetch_instr, 16'h6B11); chk("hold_pc1", fetch_pc_plus1, 16'h0012);

      // redirect while waiting on 0x0005
      lat = 3;
      do_redirect(16'h0005);
      tick();
      do_redirect(16'h0040);
      wait_valid("drop_found");
      chk("drop_pc1", fetch_pc_plus1, 16'h0041);
      chk("drop_instr", fetch_instr, 16'h7C40);

      // HLT at 0x0007
      lat = 0;
      do_redirect(16'h0007);
      wait_valid("hlt_found");
      chk("hlt_pc1", fetch_pc_plus1, 16'h0008);
      chk("hlt_instr", fetch_instr, 16'hF000);
      chk("hlt_flag", {15'b0, fetch_halted}, 16'd1);
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         tick(); #1;
         if (im_rd_en || !fetch_halted || fetch_valid) bad++;
      end
      chk("halt_quiet", 16'(bad), 16'd0);
      do_redirect(16'h0002);
      chk("resume_halted", {15'b0, fetch_halted}, 16'd0);
      wait_valid("resume_found");
      chk("resume_pc1", fetch_pc_plus1, 16'h0003);

      // PC wrap
      do_redirect(16'hFFFF);
      wait_valid("wrap_found");
      chk("wrap_pc1", fetch_pc_plus1, 16'h0000);
      chk("wrap_instr", fetch_instr, 16'h1FFF);
      #1 chk("wrap_addr", im_addr, 16'h0000);

      // randomized traffic
      use_lat = 0;
      for (int i = 0; i < 1500; i++) begin
         tick();
         stall    = ($urandom_range(0, 3) == 0);
         redirect = ($urandom_range(0, 11) == 0);
         redirect_pc = ($urandom_range(0, 7) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                   : 16'($urandom_range(0, 40));
         rdy_rand = ($urandom_range(0, 2) != 0);
      end
      tick();
      stall = 0; redirect = 0; use_lat = 1; lat = 0;

      // reset in the middle of a long wait
      do_redirect(16'h0030);
      wait_valid("pre_reset_found");
      chk("pre_reset_pc1", fetch_pc_plus1, 16'h0031);
      lat = 5;
      tick(); tick();
      #2 rst_n = 0;
      #1;
      chk("async_instr", fetch_instr, 16'h0000);
      chk("async_pc1", fetch_pc_plus1, 16'h0000);
      chk("async_valid", {15'b0, fetch_valid}, 16'd0);
      chk("async_halted", {15'b0, fetch_halted}, 16'd0);
      tick(); tick();
      rst_n = 1;
      #1;
      chk("post_reset_addr", im_addr, 16'h0000);
      chk("post_reset_rd_en", {15'b0, im_rd_en}, 16'd1);
      repeat (12) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
